// File: rtl/switch_conditioner_pkg.sv
// switch_conditioner_pkg: chord state encodings, button indices and chord patterns
package switch_conditioner_pkg;
  typedef enum logic [1:0] {
    CHORD_IDLE      = 2'b00,
    CHORD_ARM_START = 2'b01,
    CHORD_ARM_RESET = 2'b10,
    CHORD_LATCHED   = 2'b11
  } chord_state_t;
  localparam int SW_UP = 0;
  localparam int SW_DN = 1;
  localparam int SW_RT = 2;
  localparam int SW_LT = 3;
  localparam logic [3:0] CHORD_START = 4'b0111;
  localparam logic [3:0] CHORD_RESET = 4'b1111;
  function automatic logic one_key(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction
endpackage

// File: rtl/switch_conditioner_debounce_filter.sv
// debounce_filter: two-flop synchroniser followed by a constant-level debouncer for one button
module debounce_filter #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic i_Clk,
  input  logic i_Reset_n,
  input  logic i_Raw,
  output logic o_Stable
);
  localparam int CW = DEBOUNCE_CYCLES > 1 ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] LIM = CW'(DEBOUNCE_CYCLES - 1);
  logic [1:0] sync;
  logic [CW-1:0] cnt;
  logic differ;
  assign differ = sync[1] != o_Stable;
  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      sync     <= '0;
      cnt      <= '0;
      o_Stable <= 1'b0;
    end else begin
      sync <= {sync[0], i_Raw};
      cnt  <= (!differ || cnt == LIM) ? '0 : cnt + CW'(1);
      if (differ && cnt == LIM) o_Stable <= sync[1];
    end
  end
endmodule

// File: rtl/switch_conditioner.sv
// switch_conditioner: turns raw buttons into debounced levels, press edges, auto-repeat moves and chord requests
module switch_conditioner
  import switch_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int REPEAT_DELAY    = 6250000,
  parameter int REPEAT_PERIOD   = 2500000,
  parameter int CHORD_HOLD      = 12500000
) (
  input  logic       i_Clk,
  input  logic       i_Reset_n,
  input  logic [3:0] i_Switch,
  output logic [3:0] o_Held,
  output logic [3:0] o_Press,
  output logic [3:0] o_Move,
  output logic       o_Start,
  output logic       o_Reset_Req,
  output logic [1:0] o_Chord_State
);
  localparam int RMAX = REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW = RMAX > 1 ? $clog2(RMAX) : 1;
  localparam int CCW = CHORD_HOLD > 1 ? $clog2(CHORD_HOLD) : 1;
  localparam logic [CCW-1:0] FIRE = CCW'(CHORD_HOLD - 2);
  chord_state_t state;
  logic [3:0] held_d;
  logic [RW-1:0] rcnt, rlim;
  logic rphase, single;
  logic [CCW-1:0] ccnt;
  for (genvar i = 0; i < 4; i++) begin : g_db
    debounce_filter #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .i_Clk    (i_Clk),
      .i_Reset_n(i_Reset_n),
      .i_Raw    (i_Switch[i]),
      .o_Stable (o_Held[i])
    );
  end
  assign single = one_key(o_Held) && state == CHORD_IDLE;
  assign rlim = rphase ? RW'(REPEAT_PERIOD - 1) : RW'(REPEAT_DELAY - 1);
  assign o_Chord_State = state;
  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      held_d  <= '0;
      o_Press <= '0;
      o_Move  <= '0;
      rcnt    <= '0;
      rphase  <= 1'b0;
    end else begin
      held_d  <= o_Held;
      o_Press <= o_Held & ~held_d;
      if (!single || o_Held != held_d) begin
        rcnt   <= '0;
        rphase <= 1'b0;
        o_Move <= single ? o_Held & ~held_d : 4'd0;
      end else if (rcnt == rlim) begin
        rcnt   <= '0;
        rphase <= 1'b1;
        o_Move <= o_Held;
      end else begin
        rcnt   <= rcnt + RW'(1);
        o_Move <= '0;
      end
    end
  end
  // The counter defaults to zero so every state change starts the hold time afresh.
  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state       <= CHORD_IDLE;
      ccnt        <= '0;
      o_Start     <= 1'b0;
      o_Reset_Req <= 1'b0;
    end else begin
      o_Start     <= 1'b0;
      o_Reset_Req <= 1'b0;
      ccnt        <= '0;
      case (state)
        CHORD_IDLE:
          state <= o_Held == CHORD_RESET ? CHORD_ARM_RESET :
                   o_Held == CHORD_START ? CHORD_ARM_START : CHORD_IDLE;
        CHORD_ARM_START:
          if (o_Held == CHORD_RESET) state <= CHORD_ARM_RESET;
          else if (o_Held != CHORD_START) state <= CHORD_IDLE;
          else if (ccnt == FIRE) begin
            o_Start <= 1'b1;
            state   <= CHORD_LATCHED;
          end else ccnt <= ccnt + CCW'(1);
        CHORD_ARM_RESET:
          if (o_Held != CHORD_RESET) state <= CHORD_IDLE;
          else if (ccnt == FIRE) begin
            o_Reset_Req <= 1'b1;
            state       <= CHORD_LATCHED;
          end else ccnt <= ccnt + CCW'(1);
        default:
          if (o_Held == 4'd0) state <= CHORD_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_switch_conditioner.sv
// tb_switch_conditioner: directed checks of debounce, press, auto-repeat and chord behaviour
module tb_switch_conditioner;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0] sw = 4'd0;
  logic [3:0] held, press, move;
  logic start, rreq;
  logic [1:0] state;
  int n_cmp = 0, n_bad = 0;
  int n_press[4] = '{default: 0};
  int n_move[4] = '{default: 0};
  int n_start = 0, n_rreq = 0;
  int p0, m0, m1, s0, r0, msum;
  always #5 clk = ~clk;
  switch_conditioner #(
    .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(20), .REPEAT_PERIOD(8), .CHORD_HOLD(16)
  ) dut (
    .i_Clk(clk), .i_Reset_n(rst_n), .i_Switch(sw), .o_Held(held), .o_Press(press),
    .o_Move(move), .o_Start(start), .o_Reset_Req(rreq), .o_Chord_State(state)
  );
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      n_press[i] += int'(press[i]);
      n_move[i]  += int'(move[i]);
    end
    n_start += int'(start);
    n_rreq  += int'(rreq);
  end
  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask
  function automatic int moves();
    return n_move[0] + n_move[1] + n_move[2] + n_move[3];
  endfunction
  task automatic all_zero(input string tag);
    chk({tag, "_held"}, int'(held), 0);
    chk({tag, "_press"}, int'(press), 0);
    chk({tag, "_move"}, int'(move), 0);
    chk({tag, "_start"}, int'(start), 0);
    chk({tag, "_rreq"}, int'(rreq), 0);
    chk({tag, "_state"}, int'(state), 0);
  endtask
  initial begin
    #1;
    all_zero("rst");
    tick(2);
    rst_n = 1'b1;
    tick(2);
    // 1: bounce on button 0
    p0 = n_press[0];
    m0 = n_move[0];
    sw[0] = 1'b1; tick(2);
    sw[0] = 1'b0; tick(2);
    sw[0] = 1'b1; tick(2);
    sw[0] = 1'b0; tick(2);
    sw[0] = 1'b1;
    tick(5);
    chk("t1_not_yet", int'(held), 0);
    tick(1);
    chk("t1_rise", int'(held), 1);
    tick(1);
    chk("t1_press", int'(press), 1);
    chk("t1_move", int'(move), 1);
    tick(3);
    sw[0] = 1'b0;
    tick(12);
    chk("t1_released", int'(held), 0);
    chk("t1_press_cnt", n_press[0] - p0, 1);
    chk("t1_move_cnt", n_move[0] - m0, 1);
    // 2: auto-repeat on button 1
    m1 = n_move[1];
    sw[1] = 1'b1;
    tick(6);
    chk("t2_rise", int'(held), 2);
    for (int k = 1; k <= 70; k++) begin
      tick(1);
      chk($sformatf("t2_move_%0d", k), int'(move),
          (k == 1 || k == 21 || k == 29 || k == 37 || k == 45 || k == 53) ? 2 : 0);
      if (k == 54) sw[1] = 1'b0;
    end
    chk("t2_released", int'(held), 0);
    chk("t2_move_cnt", n_move[1] - m1, 6);
    // 3: start chord
    s0 = n_start;
    r0 = n_rreq;
    msum = moves();
    sw = 4'b0111;
    tick(6);
    chk("t3_held", int'(held), 7);
    tick(1);
    chk("t3_arm", int'(state), 1);
    for (int k = 2; k <= 30; k++) begin
      tick(1);
      chk($sformatf("t3_start_%0d", k), int'(start), k == 16 ? 1 : 0);
      chk($sformatf("t3_rreq_%0d", k), int'(rreq), 0);
    end
    chk("t3_latched", int'(state), 3);
    sw = 4'b0000;
    tick(6);
    chk("t3_latched_rel", int'(state), 3);
    tick(1);
    chk("t3_idle", int'(state), 0);
    chk("t3_start_cnt", n_start - s0, 1);
    chk("t3_no_move", moves() - msum, 0);
    // 4: escalation from start chord to reset chord
    s0 = n_start;
    r0 = n_rreq;
    sw = 4'b0111;
    tick(6);
    chk("t4_held0", int'(held), 7);
    tick(4);
    sw = 4'b1111;
    tick(6);
    chk("t4_held1", int'(held), 15);
    chk("t4_arm_start", int'(state), 1);
    for (int k = 1; k <= 20; k++) begin
      tick(1);
      if (k == 1) chk("t4_arm_reset", int'(state), 2);
      chk($sformatf("t4_rreq_%0d", k), int'(rreq), k == 16 ? 1 : 0);
      chk($sformatf("t4_start_%0d", k), int'(start), 0);
    end
    chk("t4_latched", int'(state), 3);
    sw = 4'b0000;
    tick(6);
    chk("t4_latched_rel", int'(state), 3);
    tick(1);
    chk("t4_idle", int'(state), 0);
    chk("t4_start_cnt", n_start - s0, 0);
    chk("t4_rreq_cnt", n_rreq - r0, 1);
    // 5: abort reset chord, then a fresh full hold
    s0 = n_start;
    r0 = n_rreq;
    sw = 4'b1111;
    tick(6);
    chk("t5_held", int'(held), 15);
    tick(4);
    sw = 4'b0110;
    for (int k = 1; k <= 7; k++) begin
      tick(1);
      chk($sformatf("t5_abort_rreq_%0d", k), int'(rreq), 0);
    end
    chk("t5_held_ab", int'(held), 6);
    chk("t5_idle", int'(state), 0);
    sw = 4'b1111;
    tick(6);
    chk("t5_held2", int'(held), 15);
    for (int k = 1; k <= 20; k++) begin
      tick(1);
      chk($sformatf("t5_rreq_%0d", k), int'(rreq), k == 16 ? 1 : 0);
    end
    sw = 4'b0000;
    tick(8);
    chk("t5_idle_end", int'(state), 0);
    chk("t5_start_cnt", n_start - s0, 0);
    chk("t5_rreq_cnt", n_rreq - r0, 1);
    // 6: reset in the middle of ARM_RESET
    r0 = n_rreq;
    sw = 4'b1111;
    tick(11);
    chk("t6_arm_reset", int'(state), 2);
    rst_n = 1'b0;
    #1;
    all_zero("t6_rst");
    tick(3);
    chk("t6_rst_state", int'(state), 0);
    rst_n = 1'b1;
    tick(5);
    chk("t6_not_yet", int'(held), 0);
    tick(1);
    chk("t6_rise", int'(held), 15);
    for (int k = 1; k <= 16; k++) begin
      tick(1);
      chk($sformatf("t6_rreq_%0d", k), int'(rreq), k == 16 ? 1 : 0);
    end
    chk("t6_rreq_cnt", n_rreq - r0, 1);
    sw = 4'b0000;
    tick(8);
    chk("t6_idle_end", int'(state), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
